// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the instruction-fetch memory responder.
// Holds the FSM state type, the RISC-V NOP word and the word size in bytes.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RV_NOP     = 32'h0000_0013;
    localparam int          WORD_BYTES = 4;

endpackage

// File: rtl/instr_store.sv
// Instruction store: DEPTH x DATA_W words, synchronous write, asynchronous read.
// Contents are never reset, so a preloaded program survives a responder reset.
module instr_store #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [DATA_W-1:0]        i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [DATA_W-1:0]        o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // A same-edge write is seen by the reader only after the edge (read-before-write).
    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instr_fetch_responder.sv
// Memory-side responder for instruction fetches: accepts one byte-addressed request at a
// time, waits WAIT_CYCLES, then holds the word (or a NOP error response) until taken.
module instr_fetch_responder
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     req,
    input  logic [ADDR_W-1:0]        addr,
    output logic                     gnt,
    output logic                     rvalid,
    output logic [DATA_W-1:0]        rdata,
    output logic                     rerr,
    input  logic                     rready,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [DATA_W-1:0]        prog_data
);

    localparam int IDX_W   = $clog2(DEPTH);
    localparam int IDX_LSB = $clog2(WORD_BYTES);
    localparam int CNT_W   = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

    fetch_state_t      r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_rvalid;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rerr;

    logic              w_accept;
    logic [ADDR_W-1:0] w_chk_addr;
    logic              w_err;
    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_word;
    logic [DATA_W-1:0] w_resp_data;

    assign w_accept = RST & req & (r_state == IDLE);

    // With zero wait the response is captured on the accept edge from the live address.
    assign w_chk_addr  = (r_state == IDLE) ? addr : r_addr;
    assign w_idx       = w_chk_addr[IDX_W+IDX_LSB-1:IDX_LSB];
    assign w_err       = (|w_chk_addr[IDX_LSB-1:0]) | (|w_chk_addr[ADDR_W-1:IDX_W+IDX_LSB]);
    assign w_resp_data = w_err ? DATA_W'(RV_NOP) : w_word;

    instr_store #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_store (
        .i_clk   (CLK),
        .i_we    (prog_we),
        .i_waddr (prog_addr),
        .i_wdata (prog_data),
        .i_raddr (w_idx),
        .o_rdata (w_word)
    );

    always_ff @(posedge CLK) begin
        if (w_accept) begin
            r_addr <= addr;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rerr   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_cnt <= CNT_W'(WAIT_CYCLES);
                        if (WAIT_CYCLES == 0) begin
                            r_state  <= RESP;
                            r_rvalid <= 1'b1;
                            r_rdata  <= w_resp_data;
                            r_rerr   <= w_err;
                        end else begin
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == CNT_W'(1)) begin
                        r_state  <= RESP;
                        r_cnt    <= '0;
                        r_rvalid <= 1'b1;
                        r_rdata  <= w_resp_data;
                        r_rerr   <= w_err;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rready) begin
                        r_state  <= IDLE;
                        r_rvalid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign gnt    = w_accept;
    assign rvalid = r_rvalid;
    assign rdata  = r_rdata;
    assign rerr   = r_rerr;

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Directed bench for instr_fetch_responder: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 one.
// Inputs change #1 after the rising edge; outputs are sampled on the falling edge.
module tb_instr_fetch_responder;

    logic        clk = 1'b0;
    logic        rst_n, req, rready, prog_we;
    logic [63:0] addr;
    logic        gnt, rvalid, rerr;
    logic [31:0] rdata, prog_data;
    logic [7:0]  prog_addr;

    logic        rst0_n, req0, rready0, prog_we0;
    logic [63:0] addr0;
    logic        gnt0, rvalid0, rerr0;
    logic [31:0] rdata0, prog_data0;
    logic [7:0]  prog_addr0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    instr_fetch_responder #(.ADDR_W(64), .DATA_W(32), .DEPTH(256), .WAIT_CYCLES(2)) dut (
        .CLK(clk), .RST(rst_n), .req(req), .addr(addr), .gnt(gnt), .rvalid(rvalid),
        .rdata(rdata), .rerr(rerr), .rready(rready), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data)
    );

    instr_fetch_responder #(.ADDR_W(64), .DATA_W(32), .DEPTH(256), .WAIT_CYCLES(0)) dut0 (
        .CLK(clk), .RST(rst0_n), .req(req0), .addr(addr0), .gnt(gnt0), .rvalid(rvalid0),
        .rdata(rdata0), .rerr(rerr0), .rready(rready0), .prog_we(prog_we0),
        .prog_addr(prog_addr0), .prog_data(prog_data0)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sword(input int i);
        return (i == 1) ? 32'h0050_0093 : (32'hA5A5_0000 | 32'(i));
    endfunction

    task automatic prog(input bit u0, input logic [7:0] idx, input logic [31:0] d);
        if (u0) begin prog_we0 = 1'b1; prog_addr0 = idx; prog_data0 = d; end
        else    begin prog_we  = 1'b1; prog_addr  = idx; prog_data  = d; end
        @(posedge clk); #1;
        prog_we  = 1'b0;
        prog_we0 = 1'b0;
    endtask

    // Entered #1 after a rising edge with the chosen instance idle; leaves #1 after the handshake edge.
    task automatic fetch(input bit u0, input logic [63:0] a, input logic [31:0] ed,
                         input logic ee, input string tag);
        int cyc;
        if (u0) begin req0 = 1'b1; addr0 = a; rready0 = 1'b1; end
        else    begin req  = 1'b1; addr  = a; rready  = 1'b1; end
        @(negedge clk);
        check_val({tag, ".gnt"}, u0 ? gnt0 : gnt, 1);
        @(posedge clk); #1;
        req  = 1'b0;
        req0 = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(u0 ? rvalid0 : rvalid) && cyc < 20);
        check_val({tag, ".lat"}, cyc, u0 ? 1 : 3);
        check_val({tag, ".rdata"}, u0 ? rdata0 : rdata, ed);
        check_val({tag, ".rerr"}, u0 ? rerr0 : rerr, ee);
        $display("[TB] fetch %s inst=%0d addr=%0h rdata=%08h rerr=%0d latency=%0d",
                 tag, u0 ? 0 : 2, a, u0 ? rdata0 : rdata, u0 ? rerr0 : rerr, cyc);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst_n = 1'b0; req = 1'b1; addr = '0; rready = 1'b0;
        prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        rst0_n = 1'b0; req0 = 1'b1; addr0 = '0; rready0 = 1'b0;
        prog_we0 = 1'b0; prog_addr0 = '0; prog_data0 = '0;

        // Reset held for three edges with req asserted
        repeat (3) begin
            @(negedge clk);
            check_val("rst.gnt", gnt, 0);
            check_val("rst.rvalid", rvalid, 0);
            check_val("rst.rdata", rdata, 0);
            check_val("rst.rerr", rerr, 0);
            check_val("rst.gnt0", gnt0, 0);
            $display("[TB] reset cycle gnt=%0d rvalid=%0d", gnt, rvalid);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; rst0_n = 1'b1; req = 1'b0; req0 = 1'b0;

        for (int i = 0; i < 8; i++) prog(1'b0, 8'(i), sword(i));
        prog(1'b0, 8'd255, 32'hDEAD_BEEF);
        prog(1'b1, 8'd5,   32'h0BAD_F00D);
        prog(1'b1, 8'd10,  32'h1111_2222);

        fetch(1'b0, 64'd4, 32'h0050_0093, 1'b0, "basic");

        // Backpressure: response held 5 cycles while a second request waits
        rready = 1'b0; req = 1'b1; addr = 64'd8;
        @(negedge clk);
        check_val("bp.gnt", gnt, 1);
        @(posedge clk); #1;
        addr = 64'd12;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!rvalid && cyc < 20);
        check_val("bp.lat", cyc, 3);
        for (int k = 0; k < 5; k++) begin
            check_val("bp.rvalid", rvalid, 1);
            check_val("bp.rdata", rdata, sword(2));
            check_val("bp.gnt_busy", gnt, 0);
            $display("[TB] backpressure hold %0d rdata=%08h", k, rdata);
            @(posedge clk); #1;
            @(negedge clk);
        end
        rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("bp.rvalid_drop", rvalid, 0);
        check_val("bp.gnt_next", gnt, 1);
        @(posedge clk); #1;
        req = 1'b0;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!rvalid && cyc < 20);
        check_val("bp2.lat", cyc, 3);
        check_val("bp2.rdata", rdata, sword(3));
        $display("[TB] backpressure follow-up rdata=%08h", rdata);
        @(posedge clk); #1;

        fetch(1'b0, 64'd6,            32'h0000_0013, 1'b1, "misalign");
        fetch(1'b0, 64'd1024,         32'h0000_0013, 1'b1, "range1024");
        fetch(1'b0, 64'h1_0000_0000,  32'h0000_0013, 1'b1, "range_hi");
        fetch(1'b0, 64'd1020,         32'hDEAD_BEEF, 1'b0, "last_word");

        for (int i = 0; i < 8; i++) fetch(1'b0, 64'(4 * i), sword(i), 1'b0, "stream");

        // Reset while in WAIT aborts the fetch
        req = 1'b1; addr = 64'd4;
        @(negedge clk);
        check_val("abort.gnt", gnt, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check_val("abort.wait_rvalid", rvalid, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_val("abort.gnt_rst", gnt, 0);
        check_val("abort.rdata_rst", rdata, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; req = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check_val("abort.rvalid", rvalid, 0);
        end
        $display("[TB] reset mid-wait aborted, rvalid=%0d", rvalid);
        @(posedge clk); #1;
        fetch(1'b0, 64'd4, 32'h0050_0093, 1'b0, "refetch");

        fetch(1'b1, 64'd20, 32'h0BAD_F00D, 1'b0, "w0");
        fetch(1'b1, 64'd7,  32'h0000_0013, 1'b1, "w0_err");

        // Write on the capture edge to the fetched word: old word is returned
        req0 = 1'b1; addr0 = 64'd40; rready0 = 1'b1;
        prog_we0 = 1'b1; prog_addr0 = 8'd10; prog_data0 = 32'h3333_4444;
        @(negedge clk);
        check_val("rbw.gnt", gnt0, 1);
        @(posedge clk); #1;
        req0 = 1'b0; prog_we0 = 1'b0;
        @(negedge clk);
        check_val("rbw.rvalid", rvalid0, 1);
        check_val("rbw.rdata", rdata0, 32'h1111_2222);
        $display("[TB] read-before-write rdata=%08h", rdata0);
        @(posedge clk); #1;
        fetch(1'b1, 64'd40, 32'h3333_4444, 1'b0, "rbw_new");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
